// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO constants, response codes, handshake FSM states and helpers.
package mmio_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int CLINT_MSIP     = 'h0000;
  localparam int CLINT_MTIMECMP = 'h0008;
  localparam int CLINT_MTIME    = 'h0010;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;
  function automatic logic [63:0] strb_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [7:0] strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/axi_ift.sv
// AXI_ift: AXI-lite port bundle between the MMIO hub and its slaves.
interface AXI_ift #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awport;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arport;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport Master (
    output awaddr, awport, awvalid, wdata, wstrb, wvalid, bready, araddr, arport, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport Slave (
    input  awaddr, awport, awvalid, wdata, wstrb, wvalid, bready, araddr, arport, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/clint_mtime_counter.sv
// clint_mtime_counter: prescaled 64-bit mtime with a byte-masked load that wins over the tick.
module clint_mtime_counter
  import mmio_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld,
  input  logic [63:0] ld_data,
  input  logic [7:0]  ld_strb,
  output logic [63:0] mtime
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          tick;
  always_comb begin
    tick    = pre_q == PW'(TICK_DIV - 1);
    pre_d   = tick ? '0 : pre_q + PW'(1);
    mtime_d = ld ? strb_merge(mtime_q, ld_data, ld_strb) : mtime_q + {63'b0, tick};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q   <= '0;
      mtime_q <= '0;
    end else begin
      pre_q   <= pre_d;
      mtime_q <= mtime_d;
    end
  end
  assign mtime = mtime_q;
endmodule

// File: rtl/axi_lite_clint_slave.sv
// axi_lite_clint_slave: AXI-lite CLINT responder holding msip/mtimecmp/mtime and driving msip/mtip.
module axi_lite_clint_slave
  import mmio_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int OFFSET_BITS    = 14,
  parameter int TICK_DIV       = 1
) (
  input  logic  clk,
  input  logic  rstn,
  AXI_ift.Slave slv,
  output logic  msip,
  output logic  mtip
);
  typedef logic [OFFSET_BITS-1:0] off_t;
  localparam off_t OFF_MSIP     = off_t'(CLINT_MSIP);
  localparam off_t OFF_MTIMECMP = off_t'(CLINT_MTIMECMP);
  localparam off_t OFF_MTIME    = off_t'(CLINT_MTIME);
  localparam int   SW           = AXI_DATA_WIDTH / 8;
  wr_state_t               wr_state_q, wr_state_d;
  rd_state_t               rd_state_q, rd_state_d;
  logic                    aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
  off_t                    aw_off_q, aw_off_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d, wr_data;
  logic [SW-1:0]           w_strb_q, w_strb_d, wr_strb;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [63:0]             rdata_q, rdata_d, mtimecmp_q, mtimecmp_d, mtime;
  logic                    msip_q, msip_d, mtip_q, mtip_d;
  logic                    aw_hs, w_hs, ar_hs, commit, mtime_ld;
  off_t                    wr_off, rd_off;
  logic                    unused_ok;
  function automatic logic mapped(input off_t o);
    return o == OFF_MSIP || o == OFF_MTIMECMP || o == OFF_MTIME;
  endfunction
  assign slv.awready = wr_state_q == W_IDLE && !aw_vld_q;
  assign slv.wready  = wr_state_q == W_IDLE && !w_vld_q;
  assign slv.bvalid  = wr_state_q == W_RESP;
  assign slv.bresp   = bresp_q;
  assign slv.arready = rd_state_q == R_IDLE;
  assign slv.rvalid  = rd_state_q == R_RESP;
  assign slv.rresp   = rresp_q;
  assign slv.rdata   = rdata_q;
  assign msip        = msip_q;
  assign mtip        = mtip_q;
  assign unused_ok   = ^{slv.awaddr[AXI_ADDR_WIDTH-1:OFFSET_BITS], slv.araddr[AXI_ADDR_WIDTH-1:OFFSET_BITS],
                         slv.awport, slv.arport};
  // AW and W may arrive in any order; a held half merges with the live other half at commit.
  always_comb begin
    aw_hs      = slv.awvalid & slv.awready;
    w_hs       = slv.wvalid & slv.wready;
    wr_off     = aw_vld_q ? aw_off_q : slv.awaddr[OFFSET_BITS-1:0];
    wr_data    = w_vld_q ? w_data_q : slv.wdata;
    wr_strb    = w_vld_q ? w_strb_q : slv.wstrb;
    commit     = wr_state_q == W_IDLE && (aw_vld_q || aw_hs) && (w_vld_q || w_hs);
    aw_vld_d   = !commit && (aw_vld_q || aw_hs);
    w_vld_d    = !commit && (w_vld_q || w_hs);
    aw_off_d   = aw_hs ? slv.awaddr[OFFSET_BITS-1:0] : aw_off_q;
    w_data_d   = w_hs ? slv.wdata : w_data_q;
    w_strb_d   = w_hs ? slv.wstrb : w_strb_q;
    wr_state_d = commit ? W_RESP : (wr_state_q == W_RESP && slv.bready) ? W_IDLE : wr_state_q;
    bresp_d    = commit ? (mapped(wr_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : bresp_q;
    msip_d     = commit && wr_off == OFF_MSIP && wr_strb[0] ? wr_data[0] : msip_q;
    mtimecmp_d = commit && wr_off == OFF_MTIMECMP ? strb_merge(mtimecmp_q, wr_data, wr_strb) : mtimecmp_q;
    mtime_ld   = commit && wr_off == OFF_MTIME;
    mtip_d     = mtime >= mtimecmp_q;
    ar_hs      = slv.arvalid & slv.arready;
    rd_off     = slv.araddr[OFFSET_BITS-1:0];
    rd_state_d = ar_hs ? R_RESP : (rd_state_q == R_RESP && slv.rready) ? R_IDLE : rd_state_q;
    rresp_d    = ar_hs ? (mapped(rd_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : rresp_q;
    rdata_d    = !ar_hs                 ? rdata_q :
                 rd_off == OFF_MSIP     ? {63'b0, msip_q} :
                 rd_off == OFF_MTIMECMP ? mtimecmp_q :
                 rd_off == OFF_MTIME    ? mtime : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_vld_q   <= 1'b0;
      w_vld_q    <= 1'b0;
      aw_off_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= AXI_RESP_OKAY;
      rresp_q    <= AXI_RESP_OKAY;
      rdata_q    <= '0;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      mtimecmp_q <= '1;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_vld_q   <= aw_vld_d;
      w_vld_q    <= w_vld_d;
      aw_off_q   <= aw_off_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end
  clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk    (clk),
    .rstn   (rstn),
    .ld     (mtime_ld),
    .ld_data(wr_data),
    .ld_strb(wr_strb),
    .mtime  (mtime)
  );
endmodule
